// File: rtl/k_and_s_pkg.sv
// ---------------------------------------------------------------------------
// k_and_s_pkg
// Shared types and constants for the K&S processor.
//   decoded_instruction_type : instruction class decoded from the IR
//   ctrl_state_type          : sequencer states of control_unit
//   ALU_*                    : encodings of the data_path ALU op select
//   ctrl_out_type            : bundle of every control_unit output strobe
//   alu_op_of()              : ALU op select for an arithmetic/logic class
// ---------------------------------------------------------------------------
package k_and_s_pkg;

    // Code 4'hF is left unassigned; the sequencer treats it like a NOP.
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_HALT   = 4'd14
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC_ALU = 3'd2,
        S_LOAD     = 3'd3,
        S_STORE    = 3'd4,
        S_MOVE     = 3'd5,
        S_BRANCH   = 3'd6,
        S_HALT     = 3'd7
    } ctrl_state_type;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] operation;
        logic       write_reg_enable;
        logic       flags_reg_enable;
        logic       ram_write_enable;
        logic       halt;
    } ctrl_out_type;

    // Non-ALU classes fall back to ADD, which is also the idle op select.
    function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
        logic [1:0] op;
        op = ALU_ADD;
        unique case (instr)
            I_AND:   op = ALU_AND;
            I_OR:    op = ALU_OR;
            I_SUB:   op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Moore sequencer for the K&S processor. Every instruction runs
// FETCH -> DECODE -> one execute state (NOP skips execute, HALT parks).
//
// Ports
//   clk                  in   system clock, rising edge
//   rst                  in   synchronous active-high reset; while high every
//                             output is held at 0
//   decoded_instruction  in   current IR decode from data_path
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow      in   registered ALU flags from data_path
//   branch               out  PC loads IR address instead of PC+1
//   pc_enable            out  PC update strobe
//   ir_enable            out  IR load strobe
//   addr_sel             out  RAM address source: 0 = PC, 1 = IR address
//   c_sel                out  register write source: 0 = ALU, 1 = RAM data
//   operation            out  ALU op select (ALU_* in k_and_s_pkg)
//   write_reg_enable     out  register-file write
//   flags_reg_enable     out  flag-register write
//   ram_write_enable     out  RAM write strobe
//   halt                 out  core stopped
// ---------------------------------------------------------------------------
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_type state_q;
    ctrl_state_type state_d;
    logic           taken;
    ctrl_out_type   ctrl;

    // No branch condition looks at unsigned overflow; the flag is carried
    // on the interface so data_path can be wired uniformly.
    logic unused_flag;
    assign unused_flag = unsigned_overflow;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs, independent of the order
    // the simulator evaluates always blocks in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR:  state_d = S_EXEC_ALU;
                    I_LOAD:                     state_d = S_LOAD;
                    I_STORE:                    state_d = S_STORE;
                    I_MOVE:                     state_d = S_MOVE;
                    I_BRANCH, I_BZERO, I_BNZERO,
                    I_BNEG, I_BNNEG, I_BOV:     state_d = S_BRANCH;
                    I_HALT:                     state_d = S_HALT;
                    default:                    state_d = S_FETCH;
                endcase
            end
            S_EXEC_ALU, S_LOAD, S_STORE,
            S_MOVE, S_BRANCH:                   state_d = S_FETCH;
            S_HALT:                             state_d = S_HALT;
            default:                            state_d = S_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Branch condition. The flags are registered in data_path, so a flag
    // written by the previous ALU instruction is already visible here.
    // -----------------------------------------------------------------------
    always_comb begin
        taken = 1'b0;
        unique case (decoded_instruction)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = !zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = !neg_op;
            I_BOV:    taken = signed_overflow;
            default:  taken = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Reset overrides the state so no strobe (in particular a
    // RAM write caught mid-STORE) can fire while rst is high.
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    ctrl.ir_enable = 1'b1;
                    ctrl.pc_enable = 1'b1;
                end
                S_DECODE: ;
                S_EXEC_ALU: begin
                    ctrl.operation        = alu_op_of(decoded_instruction);
                    ctrl.write_reg_enable = 1'b1;
                    ctrl.flags_reg_enable = 1'b1;
                end
                S_LOAD: begin
                    ctrl.addr_sel         = 1'b1;
                    ctrl.c_sel            = 1'b1;
                    ctrl.write_reg_enable = 1'b1;
                end
                S_STORE: begin
                    ctrl.addr_sel         = 1'b1;
                    ctrl.ram_write_enable = 1'b1;
                end
                S_MOVE: begin
                    // OR of a register with itself copies it through the ALU
                    // without touching the flags.
                    ctrl.operation        = ALU_OR;
                    ctrl.write_reg_enable = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.pc_enable = taken;
                    ctrl.branch    = taken;
                end
                S_HALT: ctrl.halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign branch           = ctrl.branch;
    assign pc_enable        = ctrl.pc_enable;
    assign ir_enable        = ctrl.ir_enable;
    assign addr_sel         = ctrl.addr_sel;
    assign c_sel            = ctrl.c_sel;
    assign operation        = ctrl.operation;
    assign write_reg_enable = ctrl.write_reg_enable;
    assign flags_reg_enable = ctrl.flags_reg_enable;
    assign ram_write_enable = ctrl.ram_write_enable;
    assign halt             = ctrl.halt;

endmodule
